// File: rtl/hc595_serial_driver.sv
// hc595_serial_driver: shifts a byte (raw or 7-seg decoded) MSB-first into
// an SN74HC595 and latches it, with SRCLK/RCLK derived from the system clock.
module hc595_serial_driver #(
  parameter int DIV   = 2,
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RSTbar,
  input  logic [WIDTH-1:0] DIN,
  input  logic             HEX_MODE,
  input  logic             LOAD,
  input  logic             CLEAR,
  input  logic             EN,
  output logic             SER,
  output logic             SRCLK,
  output logic             RCLK,
  output logic             SRCLRbar,
  output logic             OEbar,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CLAST = CW'(DIV - 1);
  localparam logic [IW-1:0] ILAST = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, SHIFT_LO, SHIFT_HI, LATCH, CLR, FIN
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_cnt;
  logic             r_ser;
  logic             r_srclk;
  logic             r_rclk;
  logic             r_srclrb;
  logic             r_oeb;
  logic             r_busy;
  logic             r_done;

  logic [7:0]       w_seg;
  logic [WIDTH-1:0] w_pat;
  logic             w_last;

  always_comb begin
    w_seg = 8'h00;
    unique case (DIN[3:0])
      4'h0: w_seg = 8'hFC;
      4'h1: w_seg = 8'h60;
      4'h2: w_seg = 8'hDA;
      4'h3: w_seg = 8'hF2;
      4'h4: w_seg = 8'h66;
      4'h5: w_seg = 8'hB6;
      4'h6: w_seg = 8'hBE;
      4'h7: w_seg = 8'hE0;
      4'h8: w_seg = 8'hFE;
      4'h9: w_seg = 8'hE6;
      4'hA: w_seg = 8'hEE;
      4'hB: w_seg = 8'h3E;
      4'hC: w_seg = 8'h9C;
      4'hD: w_seg = 8'h7A;
      4'hE: w_seg = 8'h9E;
      4'hF: w_seg = 8'h8E;
    endcase
  end

  assign w_pat  = HEX_MODE ? WIDTH'(w_seg) : DIN;
  assign w_last = (r_cnt == CLAST);

  always_ff @(posedge CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      r_state  <= IDLE;
      r_sreg   <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_ser    <= 1'b0;
      r_srclk  <= 1'b0;
      r_rclk   <= 1'b0;
      r_srclrb <= 1'b0;
      r_oeb    <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_oeb  <= ~EN;
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_cnt    <= '0;
          r_srclrb <= ~CLEAR;
          if (CLEAR) begin
            r_state <= CLR;
            r_busy  <= 1'b1;
          end else if (LOAD) begin
            r_sreg  <= w_pat;
            r_idx   <= ILAST;
            r_ser   <= w_pat[WIDTH-1];
            r_state <= SHIFT_LO;
            r_busy  <= 1'b1;
          end
        end
        SHIFT_LO: begin
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
          if (w_last) begin
            r_srclk <= 1'b1;
            r_state <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
          if (w_last) begin
            r_srclk <= 1'b0;
            if (r_idx == '0) begin
              r_ser   <= 1'b0;
              r_rclk  <= 1'b1;
              r_state <= LATCH;
            end else begin
              r_idx   <= r_idx - 1'b1;
              r_ser   <= r_sreg[r_idx - 1'b1];
              r_state <= SHIFT_LO;
            end
          end
        end
        LATCH: begin
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
          if (w_last) begin
            r_rclk  <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= FIN;
          end
        end
        CLR: begin
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
          // release the clear before latching so RCLK copies the blanked register
          if (w_last) begin
            r_srclrb <= 1'b1;
            r_rclk   <= 1'b1;
            r_state  <= LATCH;
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign SER      = r_ser;
  assign SRCLK    = r_srclk;
  assign RCLK     = r_rclk;
  assign SRCLRbar = r_srclrb;
  assign OEbar    = r_oeb;
  assign BUSY     = r_busy;
  assign DONE     = r_done;

endmodule

// File: tb/tb_hc595_serial_driver.sv
// tb_hc595_serial_driver: drives the serial driver against a behavioural
// '595 model and the segment table, for DIV=2 and DIV=1 instances.
module tb_hc595_serial_driver;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] din = 8'h00;
  logic       hex = 1'b0;
  logic       load = 1'b0;
  logic       clear = 1'b0;
  logic       en = 1'b0;

  logic ser, srclk, rclk, srclrb, oeb, busy, done;
  logic ser1, srclk1, rclk1, srclrb1, oeb1, busy1, done1;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] seg [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hE6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  hc595_serial_driver #(.DIV(2), .WIDTH(8)) dut (
    .CLK(clk), .RSTbar(rstn), .DIN(din), .HEX_MODE(hex),
    .LOAD(load), .CLEAR(clear), .EN(en),
    .SER(ser), .SRCLK(srclk), .RCLK(rclk), .SRCLRbar(srclrb),
    .OEbar(oeb), .BUSY(busy), .DONE(done));

  hc595_serial_driver #(.DIV(1), .WIDTH(8)) dut1 (
    .CLK(clk), .RSTbar(rstn), .DIN(din), .HEX_MODE(hex),
    .LOAD(load), .CLEAR(clear), .EN(en),
    .SER(ser1), .SRCLK(srclk1), .RCLK(rclk1), .SRCLRbar(srclrb1),
    .OEbar(oeb1), .BUSY(busy1), .DONE(done1));

  always #5 clk = ~clk;

  // Behavioural '595: shift on SRCLK rise, copy on RCLK rise, clear when SRCLRbar low
  logic [7:0] sr = 8'h00, q = 8'h00;
  logic       p_sck = 1'b0, p_rck = 1'b0, p_ser = 1'b0;
  int         n_sck = 0, n_rck = 0, n_clrlow = 0, n_viol = 0;

  always @(negedge clk) begin
    if (!srclrb) begin
      sr = 8'h00;
      n_clrlow++;
    end else if (srclk && !p_sck) begin
      sr = {sr[6:0], ser};
      n_sck++;
    end
    if (srclk && p_sck && ser !== p_ser) n_viol++;
    if (rclk && !p_rck) begin
      q = sr;
      n_rck++;
    end
    p_sck = srclk;
    p_rck = rclk;
    p_ser = ser;
  end

  logic [7:0] sr1 = 8'h00, q1 = 8'h00;
  logic       p_sck1 = 1'b0, p_rck1 = 1'b0;

  always @(negedge clk) begin
    if (!srclrb1) sr1 = 8'h00;
    else if (srclk1 && !p_sck1) sr1 = {sr1[6:0], ser1};
    if (rclk1 && !p_rck1) q1 = sr1;
    p_sck1 = srclk1;
    p_rck1 = rclk1;
  end

  task automatic xfer(input logic [7:0] d, input logic h, output int lat);
    @(negedge clk);
    din = d;
    hex = h;
    load = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      load = 1'b0;
      lat++;
    end while (!done && lat < 200);
  endtask

  task automatic test_reset();
    logic [6:0] v;
    rstn = 1'b0;
    en = 1'b0;
    repeat (3) @(negedge clk);
    v = {ser, srclk, rclk, srclrb, oeb, busy, done};
    n_cmp++;
    if (v !== 7'b0000100) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want %b", v, 7'b0000100);
    end
    rstn = 1'b1;
    @(negedge clk);
    v = {ser, srclk, rclk, srclrb, oeb, busy, done};
    n_cmp++;
    if (v !== 7'b0001100) begin
      n_err++;
      $display("FAIL post_reset_srclr: got %b want %b", v, 7'b0001100);
    end
    en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (oeb !== 1'b0) begin
      n_err++;
      $display("FAIL oe_enable: got %b want 0", oeb);
    end
  endtask

  task automatic test_hex3();
    int lat, s_sck, s_rck;
    s_sck = n_sck;
    s_rck = n_rck;
    xfer(8'h03, 1'b1, lat);
    n_cmp++;
    if (lat !== 35) begin
      n_err++;
      $display("FAIL hex3_latency: got %0d want 35", lat);
    end
    n_cmp++;
    if (n_sck - s_sck !== 8) begin
      n_err++;
      $display("FAIL hex3_srclk_rises: got %0d want 8", n_sck - s_sck);
    end
    n_cmp++;
    if (n_rck - s_rck !== 1) begin
      n_err++;
      $display("FAIL hex3_rclk_rises: got %0d want 1", n_rck - s_rck);
    end
    n_cmp++;
    if (q !== 8'hF2) begin
      n_err++;
      $display("FAIL hex3_q: got %h want f2", q);
    end
    n_cmp++;
    if ({busy, ser} !== 2'b00) begin
      n_err++;
      $display("FAIL hex3_fin_busy_ser: got %b want 00", {busy, ser});
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL hex3_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    hex = 1'b1;
    din = {4'($urandom_range(15)), 4'h0};
    load = 1'b1;
    for (int v = 0; v < 16; v++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < 200);
      n_cmp++;
      if (q !== seg[v]) begin
        n_err++;
        $display("FAIL b2b_q[%0d]: got %h want %h", v, q, seg[v]);
      end
      n_cmp++;
      if (n !== ((v == 0) ? 35 : 36)) begin
        n_err++;
        $display("FAIL b2b_period[%0d]: got %0d want %0d", v, n,
                 (v == 0) ? 35 : 36);
      end
      din = {4'($urandom_range(15)), 4'(v + 1)};
    end
    load = 1'b0;
  endtask

  task automatic test_load_ignored();
    int lat, s_sck, s_rck;
    logic [7:0] d;
    s_sck = n_sck;
    s_rck = n_rck;
    @(negedge clk);
    din = 8'hA5;
    hex = 1'b0;
    load = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      load = (lat == 10);
    end while (!done && lat < 200);
    load = 1'b0;
    n_cmp++;
    if (q !== 8'hA5 || lat !== 35) begin
      n_err++;
      $display("FAIL raw_a5: got q=%h lat=%0d want q=a5 lat=35", q, lat);
    end
    n_cmp++;
    if (n_sck - s_sck !== 8 || n_rck - s_rck !== 1) begin
      n_err++;
      $display("FAIL raw_a5_edges: got sck=%0d rck=%0d want 8 1",
               n_sck - s_sck, n_rck - s_rck);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL raw_no_queue: got busy=%b want 0", busy);
    end
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      xfer(d, 1'b0, lat);
      n_cmp++;
      if (q !== d) begin
        n_err++;
        $display("FAIL raw_rand[%0d]: got %h want %h", i, q, d);
      end
    end
    n_cmp++;
    if (n_viol !== 0) begin
      n_err++;
      $display("FAIL ser_stable: got %0d changes while SRCLK high want 0", n_viol);
    end
  endtask

  task automatic test_clear();
    int lat, s_sck, s_rck, s_clr;
    xfer(8'h08, 1'b1, lat);
    n_cmp++;
    if (q !== 8'hFE) begin
      n_err++;
      $display("FAIL clear_pre_q: got %h want fe", q);
    end
    s_sck = n_sck;
    s_rck = n_rck;
    s_clr = n_clrlow;
    @(negedge clk);
    clear = 1'b1;
    load = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      clear = 1'b0;
      load = 1'b0;
      lat++;
    end while (!done && lat < 200);
    n_cmp++;
    if (lat !== 5) begin
      n_err++;
      $display("FAIL clear_latency: got %0d want 5", lat);
    end
    n_cmp++;
    if (n_clrlow - s_clr !== 2) begin
      n_err++;
      $display("FAIL clear_srclr_low: got %0d want 2", n_clrlow - s_clr);
    end
    n_cmp++;
    if (n_sck - s_sck !== 0 || n_rck - s_rck !== 1) begin
      n_err++;
      $display("FAIL clear_edges: got sck=%0d rck=%0d want 0 1",
               n_sck - s_sck, n_rck - s_rck);
    end
    n_cmp++;
    if (q !== 8'h00) begin
      n_err++;
      $display("FAIL clear_q: got %h want 00", q);
    end
  endtask

  task automatic test_reset_mid();
    int lat, s_rck;
    logic [7:0] q0;
    logic [6:0] v;
    s_rck = n_rck;
    q0 = q;
    @(negedge clk);
    din = 8'($urandom) | 8'h80;
    hex = 1'b0;
    load = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      load = 1'b0;
      lat++;
    end while (lat < 12);
    rstn = 1'b0;
    #1;
    v = {ser, srclk, rclk, srclrb, oeb, busy, done};
    n_cmp++;
    if (v !== 7'b0000100) begin
      n_err++;
      $display("FAIL midreset_outputs: got %b want %b", v, 7'b0000100);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (60) @(negedge clk);
    n_cmp++;
    if (n_rck - s_rck !== 0 || q !== q0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_no_latch: got rck=%0d q=%h busy=%b want 0 %h 0",
               n_rck - s_rck, q, busy, q0);
    end
  endtask

  task automatic test_oe();
    int lat;
    logic [7:0] d;
    @(negedge clk);
    en = 1'b0;
    #1;
    n_cmp++;
    if (oeb !== 1'b0) begin
      n_err++;
      $display("FAIL oe_delay: got %b want 0", oeb);
    end
    @(negedge clk);
    n_cmp++;
    if (oeb !== 1'b1) begin
      n_err++;
      $display("FAIL oe_disable: got %b want 1", oeb);
    end
    en = 1'b1;
    d = 8'($urandom);
    @(negedge clk);
    din = d;
    hex = 1'b0;
    load = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      load = 1'b0;
      lat++;
      if (lat == 5) en = 1'b0;
      if (lat == 6) begin
        n_cmp++;
        if (oeb !== 1'b1) begin
          n_err++;
          $display("FAIL oe_midxfer: got %b want 1", oeb);
        end
        en = 1'b1;
      end
    end while (!done && lat < 200);
    n_cmp++;
    if (q !== d || lat !== 35) begin
      n_err++;
      $display("FAIL oe_xfer: got q=%h lat=%0d want %h 35", q, lat, d);
    end
  endtask

  task automatic test_div1();
    int lat, n;
    logic [3:0] h;
    h = 4'($urandom_range(15));
    repeat (3) @(negedge clk);
    @(negedge clk);
    din = {4'h0, h};
    hex = 1'b1;
    load = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      load = 1'b0;
      lat++;
    end while (!done1 && lat < 100);
    n_cmp++;
    if (lat !== 18) begin
      n_err++;
      $display("FAIL div1_latency: got %0d want 18", lat);
    end
    n_cmp++;
    if (q1 !== seg[h]) begin
      n_err++;
      $display("FAIL div1_q: got %h want %h", q1, seg[h]);
    end
    n = lat;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (q !== seg[h]) begin
      n_err++;
      $display("FAIL div2_q: got %h want %h", q, seg[h]);
    end
  endtask

  initial begin
    test_reset();
    test_hex3();
    test_back_to_back();
    test_load_ignored();
    test_clear();
    test_reset_mid();
    test_oe();
    test_div1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
